// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86 definitions used by the instruction-memory writer and by fetch.
//   - icode constants (IHALT .. IPOPQ)
//   - RNONE register code (no register operand)
//   - encoded instruction lengths in bytes
//   - writer FSM state type
// ---------------------------------------------------------------------------
package y86_pkg;

  // Instruction codes (upper nibble of byte 0)
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register code meaning "no register"
  localparam logic [3:0] RNONE   = 4'hF;

  // Encoded lengths: opcode only, opcode+regs, opcode+valC, opcode+regs+valC
  localparam logic [3:0] ILEN_OP     = 4'd1;
  localparam logic [3:0] ILEN_REG    = 4'd2;
  localparam logic [3:0] ILEN_DEST   = 4'd9;
  localparam logic [3:0] ILEN_FULL   = 4'd10;

  // Writer FSM states
  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } wr_state_e;

endpackage

// File: rtl/y86_ilen.sv
// ---------------------------------------------------------------------------
// y86_ilen
// Combinational instruction-length decoder. Given an icode it reports how
// many bytes the encoded instruction occupies and which optional fields it
// carries. Shared with fetch for computing valP.
// Ports:
//   icode_i        in   4  instruction code
//   len_o          out  4  encoded length in bytes (0 when illegal)
//   has_regbyte_o  out  1  instruction carries a {rA,rB} byte
//   has_valc_o     out  1  instruction carries an 8-byte constant
//   legal_o        out  1  icode is a defined Y86 instruction
// ---------------------------------------------------------------------------
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       has_regbyte_o,
  output logic       has_valc_o,
  output logic       legal_o
);

  // Straight decode of the four instruction shapes; anything above IPOPQ
  // is reported as illegal with zero length.
  always_comb begin
    len_o         = 4'd0;
    has_regbyte_o = 1'b0;
    has_valc_o    = 1'b0;
    legal_o       = 1'b1;
    case (icode_i)
      IHALT, INOP, IRET: begin
        len_o = ILEN_OP;
      end
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        len_o         = ILEN_REG;
        has_regbyte_o = 1'b1;
      end
      IJXX, ICALL: begin
        len_o      = ILEN_DEST;
        has_valc_o = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        len_o         = ILEN_FULL;
        has_regbyte_o = 1'b1;
        has_valc_o    = 1'b1;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/y86_imem_writer.sv
// ---------------------------------------------------------------------------
// y86_imem_writer
// Serialises one Y86 instruction, given as fields, into a byte-wide
// instruction memory at an internal cursor, one byte per cycle.
// Optional feature macro: IMEM_WR_BOUNDS_EN (reject writes past MEM_BYTES).
// Ports:
//   clk_i          in   1  clock
//   rst_ni         in   1  asynchronous active-low reset
//   org_valid_i    in   1  load org_addr_i into the cursor (IDLE only)
//   org_addr_i     in  64  new cursor value
//   in_valid_i     in   1  instruction fields valid
//   in_ready_o     out  1  ready to accept an instruction
//   icode_i..rB_i  in   4  instruction fields
//   valC_i         in  64  constant word
//   mem_we_o       out  1  byte write strobe
//   mem_addr_o     out 64  byte address
//   mem_wdata_o    out  8  byte data
//   done_o         out  1  pulse with last byte of an instruction
//   err_o          out  1  pulse the cycle after a rejected instruction
//   cursor_o       out 64  next free byte address
// ---------------------------------------------------------------------------
module y86_imem_writer
  import y86_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        org_valid_i,
  input  logic [63:0] org_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  ifun_i,
  input  logic [3:0]  rA_i,
  input  logic [3:0]  rB_i,
  input  logic [63:0] valC_i,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] cursor_o
);

  wr_state_e   state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] cursor_q, cursor_d;
  logic        err_q, err_d;
  logic [3:0]  icode_q, ifun_q, rA_q, rB_q, len_q;
  logic        hasReg_q;
  logic [63:0] valC_q;

  logic        load;
  logic [3:0]  inLen;
  logic        inHasReg;
  logic        inLegal;
  logic        unused_hasValC;
  logic [63:0] base;
  logic        oob;
  logic        lastByte;
  logic [2:0]  valcIdx;

  y86_ilen u_ilen (
    .icode_i       (icode_i),
    .len_o         (inLen),
    .has_regbyte_o (inHasReg),
    .has_valc_o    (unused_hasValC),
    .legal_o       (inLegal)
  );

  // An org load coinciding with an accept takes effect first, so the
  // bounds check must look at the address the write would actually use.
  assign base = org_valid_i ? org_addr_i : cursor_q;

`ifdef IMEM_WR_BOUNDS_EN
  // 65-bit sum so a cursor near 2^64 cannot wrap and slip past the check.
  assign oob = ({1'b0, base} + {61'b0, inLen}) > 65'(MEM_BYTES);
`else
  logic unused_memBytes;
  assign unused_memBytes = (MEM_BYTES != 0);
  assign oob = 1'b0;
`endif

  assign lastByte = (idx_q == (len_q - 4'd1));

  // State, index, cursor and error pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      cursor_q <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cursor_q <= cursor_d;
      err_q    <= err_d;
    end
  end

  // Instruction fields are captured only on an accepted legal instruction,
  // so changes on the inputs during EMIT never reach memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      icode_q  <= 4'd0;
      ifun_q   <= 4'd0;
      rA_q     <= RNONE;
      rB_q     <= RNONE;
      len_q    <= 4'd0;
      hasReg_q <= 1'b0;
      valC_q   <= 64'd0;
    end else if (load) begin
      icode_q  <= icode_i;
      ifun_q   <= ifun_i;
      rA_q     <= rA_i;
      rB_q     <= rB_i;
      len_q    <= inLen;
      hasReg_q <= inHasReg;
      valC_q   <= valC_i;
    end
  end

  // Next-state logic: IDLE handles org loads and accepts (rejecting illegal
  // or out-of-range instructions with an err pulse), EMIT advances one byte
  // per cycle and returns to IDLE after the last one.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cursor_d = cursor_q;
    err_d    = 1'b0;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (org_valid_i) begin
          cursor_d = org_addr_i;
        end
        if (in_valid_i) begin
          if (inLegal && !oob) begin
            state_d = S_EMIT;
            idx_d   = 4'd0;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        cursor_d = cursor_q + 64'd1;
        idx_d    = idx_q + 4'd1;
        if (lastByte) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte position inside valC: the register byte, when present, shifts
  // the constant one slot later.
  assign valcIdx = hasReg_q ? 3'(idx_q - 4'd2) : 3'(idx_q - 4'd1);

  // Byte selection for the write data bus; zero whenever not emitting.
  always_comb begin
    mem_wdata_o = 8'd0;
    if (state_q == S_EMIT) begin
      if (idx_q == 4'd0) begin
        mem_wdata_o = {icode_q, ifun_q};
      end else if (hasReg_q && (idx_q == 4'd1)) begin
        mem_wdata_o = {rA_q, rB_q};
      end else begin
        mem_wdata_o = valC_q[{valcIdx, 3'b000} +: 8];
      end
    end
  end

  // Outputs decode straight from registers so reset clears them at once.
  assign in_ready_o = (state_q == S_IDLE);
  assign mem_we_o   = (state_q == S_EMIT);
  assign mem_addr_o = cursor_q;
  assign cursor_o   = cursor_q;
  assign done_o     = (state_q == S_EMIT) && lastByte;
  assign err_o      = err_q;

endmodule

// File: tb/tb_y86_imem_writer.sv
// ---------------------------------------------------------------------------
// tb_y86_imem_writer
// Directed self-checking bench for y86_imem_writer. Expected bytes and
// addresses are hand-encoded Y86 instructions.
// Honours IMEM_WR_BOUNDS_EN for the out-of-range and wrap cases.
// ---------------------------------------------------------------------------
module tb_y86_imem_writer;

  logic        clk;
  logic        rstN;
  logic        orgValid;
  logic [63:0] orgAddr;
  logic        inValid;
  logic        inReady;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic        memWe;
  logic [63:0] memAddr;
  logic [7:0]  memWdata;
  logic        done;
  logic        err;
  logic [63:0] cursor;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [7:0]  expBytes [0:9];

  y86_imem_writer #(
    .BASE_ADDR (64'd0),
    .MEM_BYTES (1024)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .org_valid_i (orgValid),
    .org_addr_i  (orgAddr),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .icode_i     (icode),
    .ifun_i      (ifun),
    .rA_i        (rA),
    .rB_i        (rB),
    .valC_i      (valC),
    .mem_we_o    (memWe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .done_o      (done),
    .err_o       (err),
    .cursor_o    (cursor)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one instruction (optionally with an org load) from a negedge;
  // the accept happens on the following posedge.
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [63:0] vc, input logic ov,
                               input logic [63:0] oa, input logic holdValid);
    icode    = ic;
    ifun     = fn;
    rA       = ra;
    rB       = rb;
    valC     = vc;
    orgValid = ov;
    orgAddr  = oa;
    inValid  = 1'b1;
    @(posedge clk);
    #1;
    orgValid = 1'b0;
    if (!holdValid) inValid = 1'b0;
  endtask

  // Load the cursor without an instruction.
  task automatic applyOrg(input logic [63:0] oa);
    orgValid = 1'b1;
    orgAddr  = oa;
    @(posedge clk);
    #1;
    orgValid = 1'b0;
    @(negedge clk);
    checkOutput("orgCursor", cursor, oa);
  endtask

  // Check n consecutive write cycles against expBytes, then the idle gap.
  task automatic expectEmit(input logic [63:0] startAddr, input int n,
                            input logic [63:0] endCursor);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput($sformatf("we[%0d]", k), {63'd0, memWe}, 64'd1);
      checkOutput($sformatf("addr[%0d]", k), memAddr, startAddr + 64'(k));
      checkOutput($sformatf("data[%0d]", k), {56'd0, memWdata}, {56'd0, expBytes[k]});
      checkOutput($sformatf("done[%0d]", k), {63'd0, done}, {63'd0, (k == n - 1)});
      checkOutput($sformatf("readyBusy[%0d]", k), {63'd0, inReady}, 64'd0);
    end
    @(negedge clk);
    checkOutput("readyAfter", {63'd0, inReady}, 64'd1);
    checkOutput("weAfter", {63'd0, memWe}, 64'd0);
    checkOutput("cursorAfter", cursor, endCursor);
  endtask

  initial begin
    rstN     = 1'b0;
    orgValid = 1'b0;
    orgAddr  = 64'd0;
    inValid  = 1'b0;
    icode    = 4'd0;
    ifun     = 4'd0;
    rA       = 4'd0;
    rB       = 4'd0;
    valC     = 64'd0;

    // Reset values.
    #12;
    checkOutput("rstReady", {63'd0, inReady}, 64'd1);
    checkOutput("rstWe", {63'd0, memWe}, 64'd0);
    checkOutput("rstAddr", memAddr, 64'd0);
    checkOutput("rstData", {56'd0, memWdata}, 64'd0);
    checkOutput("rstDone", {63'd0, done}, 64'd0);
    checkOutput("rstErr", {63'd0, err}, 64'd0);
    checkOutput("rstCursor", cursor, 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // irmovq $0x100, %rbx -> 30 F3 00 01 00 00 00 00 00 00 at 0..9.
    $display("[TB] irmovq at 0");
    expBytes = '{8'h30, 8'hF3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(4'h3, 4'h0, 4'hF, 4'h3, 64'h100, 1'b0, 64'd0, 1'b0);
    expectEmit(64'd0, 10, 64'd10);

    // halt then call back-to-back with in_valid held; the call fields are
    // presented during the halt EMIT and must not disturb the halt byte.
    $display("[TB] halt + call back-to-back");
    applyStimulus(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b1);
    icode = 4'h8;
    ifun  = 4'h0;
    rA    = 4'h5;
    rB    = 4'h6;
    valC  = 64'h20;
    @(negedge clk);
    checkOutput("haltWe", {63'd0, memWe}, 64'd1);
    checkOutput("haltAddr", memAddr, 64'd10);
    checkOutput("haltData", {56'd0, memWdata}, 64'h00);
    checkOutput("haltDone", {63'd0, done}, 64'd1);
    checkOutput("haltReady", {63'd0, inReady}, 64'd0);
    @(negedge clk);
    checkOutput("gapReady", {63'd0, inReady}, 64'd1);
    checkOutput("gapWe", {63'd0, memWe}, 64'd0);
    expBytes = '{8'h80, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(4'h8, 4'h0, 4'h5, 4'h6, 64'h20, 1'b0, 64'd0, 1'b0);
    expectEmit(64'd11, 9, 64'd20);

    // org_addr=4 coincident with rrmovq %rdx,%rax -> 20 20 at 4..5.
    $display("[TB] org + rrmovq");
    expBytes = '{8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(4'h2, 4'h0, 4'h2, 4'h0, 64'd0, 1'b1, 64'd4, 1'b0);
    expectEmit(64'd4, 2, 64'd6);

    // Illegal icode C: err pulse one cycle later, no writes, still ready.
    $display("[TB] illegal icode");
    applyStimulus(4'hC, 4'h0, 4'h1, 4'h2, 64'h55, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    checkOutput("illErr", {63'd0, err}, 64'd1);
    checkOutput("illWe", {63'd0, memWe}, 64'd0);
    checkOutput("illReady", {63'd0, inReady}, 64'd1);
    checkOutput("illCursor", cursor, 64'd6);
    @(negedge clk);
    checkOutput("illErrClr", {63'd0, err}, 64'd0);
    checkOutput("illWe2", {63'd0, memWe}, 64'd0);
    checkOutput("illCursor2", cursor, 64'd6);

    // Reset after the third byte of an irmovq: outputs clear immediately.
    $display("[TB] reset mid-EMIT");
    expBytes = '{8'h30, 8'h1F, 8'hEF, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(4'h3, 4'h0, 4'h1, 4'hF, 64'hBEEF, 1'b0, 64'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midData[%0d]", k), {56'd0, memWdata}, {56'd0, expBytes[k]});
      checkOutput($sformatf("midAddr[%0d]", k), memAddr, 64'd6 + 64'(k));
    end
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstWe", {63'd0, memWe}, 64'd0);
    checkOutput("midRstDone", {63'd0, done}, 64'd0);
    checkOutput("midRstCursor", cursor, 64'd0);
    checkOutput("midRstAddr", memAddr, 64'd0);
    checkOutput("midRstReady", {63'd0, inReady}, 64'd1);
    @(negedge clk);
    rstN = 1'b1;

    // rmmovq %rcx,0x0102030405060708(%rdx) at BASE_ADDR, little-endian valC.
    $display("[TB] rmmovq after reset");
    expBytes = '{8'h40, 8'h12, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    applyStimulus(4'h4, 4'h0, 4'h1, 4'h2, 64'h0102030405060708, 1'b0, 64'd0, 1'b0);
    expectEmit(64'd0, 10, 64'd10);

    // irmovq at cursor 1020: crosses MEM_BYTES=1024.
    $display("[TB] bounds case");
    applyOrg(64'd1020);
    expBytes = '{8'h30, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(4'h3, 4'h0, 4'hF, 4'h3, 64'd0, 1'b0, 64'd0, 1'b0);
`ifdef IMEM_WR_BOUNDS_EN
    @(negedge clk);
    checkOutput("oobErr", {63'd0, err}, 64'd1);
    checkOutput("oobWe", {63'd0, memWe}, 64'd0);
    checkOutput("oobCursor", cursor, 64'd1020);
    @(negedge clk);
    checkOutput("oobErrClr", {63'd0, err}, 64'd0);
`else
    expectEmit(64'd1020, 10, 64'd1030);
`endif

    // nop at the top of the address space: cursor wraps to 0.
    $display("[TB] wrap case");
    applyOrg(64'hFFFF_FFFF_FFFF_FFFF);
    expBytes = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0);
`ifdef IMEM_WR_BOUNDS_EN
    @(negedge clk);
    checkOutput("wrapErr", {63'd0, err}, 64'd1);
    checkOutput("wrapCursor", cursor, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    expectEmit(64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/y86_imem_writer.md
# y86_imem_writer

Sequential instruction-memory loader for the Y86 sequential core: the write-side counterpart of instruction fetch. It accepts one instruction as fields (`icode`, `ifun`, `rA`, `rB`, `valC`) and computes its encoded length. It then serialises the instruction into the byte-wide instruction memory, one byte per cycle, at an internal cursor, so that fetch can later read it back at the same PC. It is used by benches and boot logic to build program images without hand-written hex.

## Interface
- `BASE_ADDR`, default 0: cursor value after reset.
- `MEM_BYTES`, default 1024: instruction memory size in bytes; used only when bounds checking is compiled in.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `org_valid`  in  1  load `org_addr` into the cursor.
- `org_addr`  in  64  new cursor value.
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  block can accept an instruction.
- `icode`, `ifun`, `rA`, `rB`  in  4 each  instruction fields.
- `valC`  in  64  constant word.
- `mem_we`  out  1  byte write strobe.
- `mem_addr`  out  64  byte address.
- `mem_wdata`  out  8  byte data.
- `done`  out  1  one-cycle pulse on the last byte of an instruction.
- `err`  out  1  one-cycle pulse when an instruction is rejected.
- `cursor`  out  64  next free byte address.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - EMIT: `in_ready`=0, writing bytes.
- Transitions:
  - Accept on `in_valid & in_ready`. Legal icode goes to EMIT with byte index 0 and the fields latched. Illegal icode (>0xB) stays in IDLE.
  - EMIT returns to IDLE after the last byte.
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq: 2 bytes.
  - 7 jXX, 8 call: 9 bytes.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
- Byte order:
  - Byte 0 is `{icode,ifun}`.
  - For 2- and 10-byte forms, byte 1 is `{rA,rB}`.
  - `valC` follows little-endian (LSB first).
  - 9-byte forms have no register byte; `rA`/`rB` are ignored.
- Each EMIT cycle drives `mem_we`=1, `mem_addr`=`cursor`, `mem_wdata`=current byte, and `cursor` increments by 1 at that edge.
- Cursor arithmetic is 64-bit modulo 2^64; it wraps from FFFF_FFFF_FFFF_FFFF to 0 silently.
- `org_valid` is honoured only in IDLE and ignored in EMIT. If it coincides with an accept, the org load takes effect first and the instruction is written starting at `org_addr`.
- Illegal icode: handshake completes, `err`=1 the following cycle, no writes, cursor unchanged.

## Timing
- Reset values: state IDLE; `in_ready`=1; `mem_we`=0; `mem_addr`=`BASE_ADDR`; `mem_wdata`=0; `done`=0; `err`=0; `cursor`=`BASE_ADDR`.
- First byte write occurs in the cycle after accept.
- An n-byte instruction occupies n consecutive write cycles.
- `done` is coincident with the last `mem_we`.
- `in_ready` rises the cycle after the last write, giving an accept-to-accept interval of n+1 cycles.
- `err` is registered: asserted the cycle after accept, for exactly one cycle. `in_ready` stays 1 throughout.
- Reset mid-EMIT: outputs return to reset values immediately (asynchronously). Bytes already written stay in memory and no `done` is produced.
- Inputs are sampled only on the accept edge; changing fields during EMIT has no effect.

## Configuration
- `IMEM_WR_BOUNDS_EN` defined: at accept, if `cursor + len > MEM_BYTES`, the instruction is rejected exactly as an illegal icode (`err` pulse, no writes, cursor unchanged). `org_addr` is not checked; only the resulting write is.
- `IMEM_WR_BOUNDS_EN` undefined: no check. Writes proceed at any address and the memory model handles out-of-range addresses.

## Structure
- Shared package `y86_pkg`: icode constants (IHALT … IPOPQ), the `RNONE` = 0xF register code, and the instruction-length constants. Fetch uses the same constants.
- One sub-module `y86_ilen`: combinational icode → {length[3:0], has_regbyte, has_valC, legal}. The same unit is reusable by fetch for computing `valP`.
- The top level holds the FSM, byte index counter, cursor and latched fields.

## Test plan
- Reset, then irmovq with `icode`=3, `ifun`=0, `rA`=F, `rB`=3, `valC`=0x100 → bytes 30 F3 00 01 00 00 00 00 00 00 written at addresses 0–9 on consecutive cycles. `done` is asserted with the addr-9 write; `cursor`=10.
- halt, then call with `valC`=0x20 back-to-back (`in_valid` held) → 00 at addr 10, then 80 20 00 00 00 00 00 00 00 at addr 11–19. `in_ready` is low during each EMIT and high 1 cycle between; `cursor`=20.
- `org_valid` with `org_addr`=4 and rrmovq (`icode`=2, `ifun`=0, `rA`=2, `rB`=0) in the same cycle → 20 20 written at addresses 4–5; `cursor`=6.
- `icode`=C → no `mem_we`, `err`=1 for one cycle, `cursor` unchanged, `in_ready` stays 1.
- Reset asserted after the 3rd byte of an irmovq → `mem_we`=0 immediately, `cursor`=`BASE_ADDR`, no `done`. The next instruction starts at `BASE_ADDR`.
- `MEM_BYTES`=16 with `cursor`=10, then irmovq → with `IMEM_WR_BOUNDS_EN`: `err` pulse, no writes. Without it: writes to addresses 10–19 and `done`.
